// File: rtl/display_init_sequencer.sv
// Steps through a display init program held in an external synchronous ROM,
// handing each byte to the serial shifter or waiting out programmed delays.
module display_init_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int DELAY_UNIT = 1000,
  parameter int BYTE_BITS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sclkPosEdge,
  input  logic [9:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [9:0]        instr,
  output logic              load,
  output logic              busy,
  output logic              done
);

  localparam int DCNT_W = $clog2(255 * DELAY_UNIT + 1);
  localparam int BCNT_W = (BYTE_BITS > 1) ? $clog2(BYTE_BITS) : 1;

  localparam logic [9:0]        INSTR_IDLE = 10'h200;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
  localparam logic [BCNT_W-1:0] BIT_LAST   = BCNT_W'(BYTE_BITS - 1);
  localparam logic [DCNT_W-1:0] DELAY_MUL  = DCNT_W'(DELAY_UNIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_SEND   = 3'd3,
    S_DELAY  = 3'd4
  } state_t;

  state_t              state_r,    state_s;
  logic [ADDR_W-1:0]   rom_addr_r, rom_addr_s;
  logic [9:0]          instr_r,    instr_s;
  logic                load_r,     load_s;
  logic                busy_r,     busy_s;
  logic                done_r,     done_s;
  logic [BCNT_W-1:0]   bitcnt_r,   bitcnt_s;
  logic [DCNT_W-1:0]   dcnt_r,     dcnt_s;
  logic                advance_s;
  logic                finish_s;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_s    = state_r;
    rom_addr_s = rom_addr_r;
    instr_s    = instr_r;
    load_s     = 1'b0;
    busy_s     = busy_r;
    done_s     = done_r;
    bitcnt_s   = bitcnt_r;
    dcnt_s     = dcnt_r;
    advance_s  = 1'b0;
    finish_s   = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          rom_addr_s = '0;
          busy_s     = 1'b1;
          done_s     = 1'b0;
          state_s    = S_FETCH;
        end else begin
          state_s    = S_IDLE;
        end
      end
      S_FETCH: begin
        state_s = S_DECODE;
      end
      S_DECODE: begin
        instr_s = rom_data;
        case (rom_data[9:8])
          2'b00, 2'b01: begin
            load_s   = 1'b1;
            bitcnt_s = '0;
            state_s  = S_SEND;
          end
          2'b10: begin
            dcnt_s  = DCNT_W'(rom_data[7:0]) * DELAY_MUL;
            state_s = S_DELAY;
          end
          default: begin
            finish_s = 1'b1;
          end
        endcase
      end
      S_SEND: begin
        // load_r marks the first SEND cycle, whose edge belongs to the previous byte
        if (sclkPosEdge && !load_r) begin
          if (bitcnt_r == BIT_LAST) begin
            advance_s = 1'b1;
          end else begin
            bitcnt_s  = bitcnt_r + BCNT_W'(1);
          end
        end else begin
          bitcnt_s = bitcnt_r;
        end
      end
      S_DELAY: begin
        // A zero delay still spends one cycle here
        if (dcnt_r <= DCNT_W'(1)) begin
          advance_s = 1'b1;
        end else begin
          dcnt_s    = dcnt_r - DCNT_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    if (advance_s) begin
      if (rom_addr_r == ADDR_LAST) begin
        finish_s   = 1'b1;
      end else begin
        rom_addr_s = rom_addr_r + ADDR_W'(1);
        state_s    = S_FETCH;
      end
    end else begin
      rom_addr_s = rom_addr_s;
    end

    // Running off the end of the ROM terminates just like the end opcode
    if (finish_s) begin
      instr_s = INSTR_IDLE;
      busy_s  = 1'b0;
      done_s  = 1'b1;
      state_s = S_IDLE;
    end else begin
      instr_s = instr_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      rom_addr_r <= '0;
      instr_r    <= INSTR_IDLE;
      load_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bitcnt_r   <= '0;
      dcnt_r     <= '0;
    end else begin
      state_r    <= state_s;
      rom_addr_r <= rom_addr_s;
      instr_r    <= instr_s;
      load_r     <= load_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      bitcnt_r   <= bitcnt_s;
      dcnt_r     <= dcnt_s;
    end
  end

  assign rom_addr = rom_addr_r;
  assign instr    = instr_r;
  assign load     = load_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
